ps2_kbd_rx: RTL
===============

PS2_KBD_RX -- requirements
Module: ps2_kbd_rx

Interface
REQ-001 Parameter FILTER, default 8, number of consecutive equal synchronised samples required before the filtered PS/2 clock changes level.
REQ-002 Parameter TIMEOUT, default 65535, clk_sys cycles allowed between falling edges inside a frame before abort.
REQ-003 clk_sys  in  1  the only clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 ps2_clk  in  1  PS/2 keyboard clock from the IO block; asynchronous; idles high.
REQ-006 ps2_data  in  1  PS/2 keyboard data; asynchronous; changes on ps2_clk rising edges.
REQ-007 key_code  out  8  last decoded scancode byte, prefix bytes excluded.
REQ-008 key_extended  out  1  an E0 prefix preceded key_code.
REQ-009 key_released  out  1  an F0 prefix preceded key_code.
REQ-010 key_strobe  out  1  one-cycle pulse; key_code/key_extended/key_released valid and updated in that cycle.
REQ-011 frame_err  out  1  one-cycle pulse on parity, stop-bit or timeout failure.
REQ-012 busy  out  1  high while a frame is in progress (state not IDLE).

Function
REQ-013 ps2_clk and ps2_data each pass through a two-flop synchroniser before any use.
REQ-014 Filtered clock changes level only after FILTER consecutive synchronised samples of the new level; shorter pulses are ignored.
REQ-015 A falling edge is the filtered clock going 1->0; data is sampled from synchronised ps2_data in the cycle that edge is detected.
REQ-016 States: IDLE, DATA, PARITY, STOP; transitions occur only on falling edges or timeout.
REQ-017 IDLE: sampled 0 -> DATA with bit counter 0; sampled 1 -> stay IDLE, no error.
REQ-018 DATA: shift sample into bit (counter) of the shift register, LSB first; after the 8th bit -> PARITY.
REQ-019 PARITY: store sample -> STOP; parity is good when data ones + parity bit is odd.
REQ-020 STOP: always -> IDLE; frame valid only if sample is 1 and parity good, otherwise frame_err pulses in the following cycle and the byte is discarded.
REQ-021 Valid byte E0: set internal extended flag, no strobe; repeated E0 leaves it set.
REQ-022 Valid byte F0: set internal released flag, no strobe.
REQ-023 Any other valid byte, including E1: key_code, key_extended and key_released load byte and flags, key_strobe pulses, and both internal flags clear in the same cycle.
REQ-024 Latency: key_strobe or frame_err asserts exactly one clk_sys cycle after the stop-bit falling edge is detected.
REQ-025 Timeout counter clears on every falling edge and in IDLE; counts otherwise; on reaching TIMEOUT outside IDLE -> IDLE, frame_err pulses, internal flags clear.
REQ-026 Any frame_err clears both internal prefix flags.
REQ-027 key_code, key_extended and key_released hold their values between strobes.
REQ-028 key_strobe and frame_err are never high in the same cycle.

Reset
REQ-029 While reset is high: state IDLE, key_code 0, key_extended 0, key_released 0, key_strobe 0, frame_err 0, busy 0, internal flags 0, timeout counter 0, filtered clock 1, synchronisers 1.
REQ-030 Reset mid-frame discards the partial frame without a frame_err pulse; reset overrides every simultaneous event.

Verification
REQ-031 Frame 0x1C, parity 0, stop 1 -> one key_strobe, key_code 0x1C, key_extended 0, key_released 0, frame_err never high.
REQ-032 Frames F0, 1C -> single key_strobe (after 1C), key_code 0x1C, key_released 1, key_extended 0.
REQ-033 Frames E0, F0, 75, then 1C -> strobe with 0x75/ext 1/rel 1, then strobe with 0x1C/ext 0/rel 0.
REQ-034 Frame 0x1C with parity 1, and separately with stop 0 -> frame_err pulse one cycle after stop edge, no key_strobe, key_code unchanged.
REQ-035 Start bit plus 4 data bits, then clock held high TIMEOUT+4 cycles -> one frame_err pulse, busy 0; next valid frame 0x29 -> key_strobe, key_code 0x29.
REQ-036 With FILTER=8, 3-cycle low glitch on ps2_clk in IDLE and mid-frame -> no state, bit-count or output change; reset asserted mid-frame -> all outputs at reset values, no frame_err.

Source files
------------

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronises and de-glitches the PS/2 clock, deframes
// 11-bit frames and folds E0/F0 prefixes into flags on the following scancode.
module ps2_kbd_rx #(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 65535
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_code,
  output logic       key_extended,
  output logic       key_released,
  output logic       key_strobe,
  output logic       frame_err,
  output logic       busy,
  output logic [1:0] state_dbg,
  output logic [2:0] bit_cnt_dbg
);

  localparam int FW = (FILTER > 1) ? $clog2(FILTER + 1) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER - 1);
  localparam logic [TW-1:0] TO_LIMIT  = TW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

  logic          clk_s1_q, clk_s2_q, data_s1_q, data_s2_q;
  logic          flt_q;
  logic [FW-1:0] flt_cnt_q;
  logic          fall;

  state_e        state_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          par_q;
  logic [TW-1:0] to_cnt_q;
  logic          ext_q, rel_q;
  logic [7:0]    key_code_q;
  logic          key_ext_q, key_rel_q, strobe_q, err_q;
  logic          frame_ok;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_s1_q  <= 1'b1;
      clk_s2_q  <= 1'b1;
      data_s1_q <= 1'b1;
      data_s2_q <= 1'b1;
    end else begin
      clk_s1_q  <= ps2_clk;
      clk_s2_q  <= clk_s1_q;
      data_s1_q <= ps2_data;
      data_s2_q <= data_s1_q;
    end
  end

  // The filtered clock flips on the FILTER-th consecutive sample of the new level.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      flt_q     <= 1'b1;
      flt_cnt_q <= '0;
    end else if (clk_s2_q != flt_q) begin
      if (flt_cnt_q == FILT_LAST) begin
        flt_q     <= clk_s2_q;
        flt_cnt_q <= '0;
      end else begin
        flt_cnt_q <= flt_cnt_q + 1'b1;
      end
    end else begin
      flt_cnt_q <= '0;
    end
  end

  assign fall     = flt_q & ~clk_s2_q & (flt_cnt_q == FILT_LAST);
  assign frame_ok = data_s2_q & (^{shift_q, par_q});

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      to_cnt_q   <= '0;
      ext_q      <= 1'b0;
      rel_q      <= 1'b0;
      key_code_q <= '0;
      key_ext_q  <= 1'b0;
      key_rel_q  <= 1'b0;
      strobe_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      err_q    <= 1'b0;
      if (state_q == IDLE || fall) to_cnt_q <= '0;
      else                         to_cnt_q <= to_cnt_q + 1'b1;

      if (state_q != IDLE && !fall && to_cnt_q == TO_LIMIT) begin
        state_q <= IDLE;
        err_q   <= 1'b1;
        ext_q   <= 1'b0;
        rel_q   <= 1'b0;
      end else if (fall) begin
        case (state_q)
          IDLE: begin
            if (!data_s2_q) begin
              state_q   <= DATA;
              bit_cnt_q <= '0;
            end
          end
          DATA: begin
            shift_q[bit_cnt_q] <= data_s2_q;
            if (bit_cnt_q == 3'd7) state_q <= PARITY;
            else                   bit_cnt_q <= bit_cnt_q + 3'd1;
          end
          PARITY: begin
            par_q   <= data_s2_q;
            state_q <= STOP;
          end
          STOP: begin
            state_q <= IDLE;
            if (!frame_ok) begin
              err_q <= 1'b1;
              ext_q <= 1'b0;
              rel_q <= 1'b0;
            end else if (shift_q == 8'hE0) begin
              ext_q <= 1'b1;
            end else if (shift_q == 8'hF0) begin
              rel_q <= 1'b1;
            end else begin
              key_code_q <= shift_q;
              key_ext_q  <= ext_q;
              key_rel_q  <= rel_q;
              strobe_q   <= 1'b1;
              ext_q      <= 1'b0;
              rel_q      <= 1'b0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign key_code     = key_code_q;
  assign key_extended = key_ext_q;
  assign key_released = key_rel_q;
  assign key_strobe   = strobe_q;
  assign frame_err    = err_q;
  assign busy         = (state_q != IDLE);
  assign state_dbg    = state_q;
  assign bit_cnt_dbg  = bit_cnt_q;

endmodule
